// File: rtl/ram_arbiter.sv
// Two-master to one-slave arbiter in front of the data RAM (m0 = ifetch, m1 = load/store).
// Latency: accept in N, RAM request handshake N+1 at the earliest, response N+2; one transaction outstanding.
// Backpressure: RAM req-ready low holds REQ with stable fields; owner rsp-ready low holds RSP; no accepts meanwhile.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   m0_* / m1_*        master request (valid/ready, addr, data, sel, we) and response (valid/ready, data)
//   s_*                registered request to the RAM and its response path
//   grant_o            one-hot owner of the current transaction, 00 when idle
//   busy_o             high whenever a transaction is in flight
module ram_arbiter #(
   parameter bit RR_EN = 1'b1  // 1: round-robin on ties, 0: master 0 always wins
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req_valid_i,
   output logic        m0_req_ready_o,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_data_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   output logic        m0_rsp_valid_o,
   input  logic        m0_rsp_ready_i,
   output logic [31:0] m0_data_o,
   input  logic        m1_req_valid_i,
   output logic        m1_req_ready_o,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_data_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   output logic        m1_rsp_valid_o,
   input  logic        m1_rsp_ready_i,
   output logic [31:0] m1_data_o,
   output logic        s_req_valid_o,
   input  logic        s_req_ready_i,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_data_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   input  logic        s_rsp_valid_i,
   output logic        s_rsp_ready_o,
   input  logic [31:0] s_data_i,
   output logic [1:0]  grant_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t     state, state_nxt;
   logic       last_grant;   // 1 when m1 owned the most recently completed transaction
   logic [1:0] grant;
   logic       win0, win1;
   logic       accept, rsp_done, owner_rdy;

   // On a tie, round-robin hands the bus to whoever did not finish last.
   assign win0 = m0_req_valid_i && (!m1_req_valid_i || !RR_EN || last_grant);
   assign win1 = m1_req_valid_i && !win0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      m0_req_ready_o = 1'b0;
      m1_req_ready_o = 1'b0;
      m0_rsp_valid_o = 1'b0;
      m1_rsp_valid_o = 1'b0;
      s_req_valid_o  = 1'b0;
      s_rsp_ready_o  = 1'b0;
      accept         = 1'b0;
      rsp_done       = 1'b0;
      owner_rdy      = grant[1] ? m1_rsp_ready_i : m0_rsp_ready_i;
      case (state)
         IDLE: begin
            m0_req_ready_o = win0;
            m1_req_ready_o = win1;
            accept         = win0 || win1;
            if (accept) state_nxt = REQ;
         end
         REQ: begin
            s_req_valid_o = 1'b1;
            if (s_req_ready_i) state_nxt = RSP;
         end
         RSP: begin
            s_rsp_ready_o  = owner_rdy;
            m0_rsp_valid_o = grant[0] && s_rsp_valid_i;
            m1_rsp_valid_o = grant[1] && s_rsp_valid_i;
            rsp_done       = s_rsp_valid_i && owner_rdy;
            if (rsp_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_addr_o   <= 32'h0;
         s_data_o   <= 32'h0;
         s_sel_o    <= 4'h0;
         s_we_o     <= 1'b0;
         grant      <= 2'b00;
         last_grant <= 1'b1;
      end else if (accept) begin
         s_addr_o <= win0 ? m0_addr_i : m1_addr_i;
         s_data_o <= win0 ? m0_data_i : m1_data_i;
         s_sel_o  <= win0 ? m0_sel_i  : m1_sel_i;
         s_we_o   <= win0 ? m0_we_i   : m1_we_i;
         grant    <= {win1, win0};
      end else if (rsp_done) begin
         last_grant <= grant[1];
         grant      <= 2'b00;
      end
   end

   // Read data is broadcast; only the owner's rsp_valid qualifies it.
   assign m0_data_o = s_data_i;
   assign m1_data_o = s_data_i;
   assign grant_o   = grant;
   assign busy_o    = (state != IDLE);

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master to one-slave arbiter sitting directly upstream of the data RAM (ram slave with req/rsp valid-ready handshake).
- Master 0 is the instruction-fetch port; master 1 is the load/store port.
- Selects one master (round-robin or fixed priority), registers its request, issues it to the RAM, and routes the response back.
- One outstanding transaction at a time.

Parameters:
- RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority, master 0 always wins.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- m0_req_valid_i  input  1  master 0 request valid
- m0_req_ready_o  output  1  master 0 request accepted
- m0_addr_i  input  32  master 0 byte address
- m0_data_i  input  32  master 0 write data
- m0_sel_i  input  4  master 0 byte enables
- m0_we_i  input  1  master 0 write enable
- m0_rsp_valid_o  output  1  master 0 response valid
- m0_rsp_ready_i  input  1  master 0 response accept
- m0_data_o  output  32  master 0 read data
- m1_* (9 ports)  same directions/widths/meaning as m0_*, for master 1
- s_req_valid_o  output  1  request valid to RAM
- s_req_ready_i  input  1  RAM request ready
- s_addr_o  output  32  registered address
- s_data_o  output  32  registered write data
- s_sel_o  output  4  registered byte enables
- s_we_o  output  1  registered write enable
- s_rsp_valid_i  input  1  RAM response valid
- s_rsp_ready_o  output  1  response ready to RAM
- s_data_i  input  32  RAM read data
- grant_o  output  2  one-hot owner of current transaction; 00 in IDLE
- busy_o  output  1  high when state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=1 (so master 0 wins the first tie), all s_* request registers=0, grant_o=00.
- Reset outputs: every *_valid_o and *_ready_o = 0, busy_o=0.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - Winner computed combinationally from m0/m1_req_valid_i.
  - RR_EN=1: on a tie, the master other than last_grant wins. RR_EN=0: m0 wins ties.
  - Winner's req_ready_o=1 in the same cycle; loser's req_ready_o=0.
  - On handshake: capture addr/data/sel/we into s_* registers, set grant_o, go REQ.
  - No request valid: stay IDLE.
- REQ:
  - s_req_valid_o=1 with stable registered fields.
  - Both m*_req_ready_o=0.
  - On s_req_ready_i=1: go RSP. Otherwise hold all fields unchanged.
- RSP:
  - Owner's rsp_valid_o = s_rsp_valid_i; s_rsp_ready_o = owner's rsp_ready_i.
  - Non-owner rsp_valid_o=0.
  - On s_rsp_valid_i & s_rsp_ready_o: last_grant=owner, grant_o=00, go IDLE.
  - Writes also complete through a response handshake; the data returned on a write is don't-care.
- m0_data_o and m1_data_o are both driven with s_data_i (broadcast); only the owner's rsp_valid_o qualifies it.
- s_rsp_valid_i is ignored in IDLE and REQ; s_rsp_ready_o=0 in those states.
- Masters must hold req_valid and fields stable until req_ready. A request dropped before ready is never issued.
- Latency, with the RAM ready and responding one cycle after its request handshake:
  - master accept in cycle N;
  - RAM request handshake in N+1;
  - response in N+2;
  - next accept in N+3.
  - Peak throughput is therefore 1 transaction per 3 cycles.
- Response backpressure: RSP holds indefinitely while the owner's rsp_ready_i=0. No new request is accepted meanwhile.
- Reset mid-transaction: returns to IDLE immediately and abandons the transaction; a late s_rsp_valid_i is then ignored.
- A new request arriving in the same cycle as the response handshake is not accepted until the next cycle (IDLE).

Test Plan:
- Single read: m0 addr=0x0000_0010, we=0; RAM returns 0xDEADBEEF → m0_req_ready_o in cycle 0, s_req_valid_o in cycle 1 with s_addr_o=0x10, m0_rsp_valid_o with m0_data_o=0xDEADBEEF in cycle 2, m1_rsp_valid_o stays 0.
- Write: m1 addr=0x20, data=0x12345678, sel=4'b0011, we=1 → s_addr_o=0x20, s_data_o=0x12345678, s_sel_o=0011, s_we_o=1 in REQ; grant_o=10; one m1 response handshake.
- Round-robin: both masters valid continuously for 4 transactions, RR_EN=1 → grant order m0, m1, m0, m1. With RR_EN=0 → m0, m0, m0, m0.
- Backpressure:
  - s_req_ready_i low for 3 cycles: s_* fields stay stable and both req_ready_o stay 0.
  - Owner's rsp_ready_i low for 2 cycles: s_rsp_ready_o=0; completes on the 3rd cycle, then IDLE.
- Reset mid-op: assert rst while in RSP → next cycle busy_o=0, grant_o=00, all valids 0. A following m1-only request is granted m1; a tie is granted m0.
- Spurious response: pulse s_rsp_valid_i in IDLE → no m*_rsp_valid_o, state unchanged.
